platform_lander: RTL and testbench

- Downstream consumer of the 8 platform positions produced by the platform motion block.
- Once per frame, scans all 8 platforms against the doodle position and vertical velocity.
- Detects a landing and reports which platform was hit.
- Computes the vertical scroll distance that the platform block and the doodle controller apply on the next frame.

---
 rtl/platform_lander_if.sv | 44 ++++
 rtl/platform_lander.sv | 161 ++++++++++++++++
 tb/tb_platform_lander.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/platform_lander_if.sv
// Interface bundling the platform_lander frame inputs and scan results.
//   master : producer of doodle/platform state and frame tick, consumer of results
//   slave  : the lander itself
// Signals:
//   frame_clk                       frame tick level; its rising edge starts a scan
//   Doodle_X, Doodle_Y              doodle centre (unsigned)
//   Doodle_Y_Motion                 signed vertical velocity, positive = falling
//   Platform_X_in1..8, _Y_in1..8    platform centre X and top Y (unsigned)
//   Land, Land_Index, Scroll_Dist   registered results of the last completed scan
//   Result_valid                    one-cycle pulse while the result is fresh
//   Busy                            scan in progress
interface platform_lander_if;
  logic       frame_clk;
  logic [9:0] Doodle_X;
  logic [9:0] Doodle_Y;
  logic [9:0] Doodle_Y_Motion;
  logic [9:0] Platform_X_in1, Platform_X_in2, Platform_X_in3, Platform_X_in4;
  logic [9:0] Platform_X_in5, Platform_X_in6, Platform_X_in7, Platform_X_in8;
  logic [9:0] Platform_Y_in1, Platform_Y_in2, Platform_Y_in3, Platform_Y_in4;
  logic [9:0] Platform_Y_in5, Platform_Y_in6, Platform_Y_in7, Platform_Y_in8;
  logic       Land;
  logic [2:0] Land_Index;
  logic [9:0] Scroll_Dist;
  logic       Result_valid;
  logic       Busy;

  modport master (
    output frame_clk, Doodle_X, Doodle_Y, Doodle_Y_Motion,
    output Platform_X_in1, Platform_X_in2, Platform_X_in3, Platform_X_in4,
    output Platform_X_in5, Platform_X_in6, Platform_X_in7, Platform_X_in8,
    output Platform_Y_in1, Platform_Y_in2, Platform_Y_in3, Platform_Y_in4,
    output Platform_Y_in5, Platform_Y_in6, Platform_Y_in7, Platform_Y_in8,
    input  Land, Land_Index, Scroll_Dist, Result_valid, Busy
  );

  modport slave (
    input  frame_clk, Doodle_X, Doodle_Y, Doodle_Y_Motion,
    input  Platform_X_in1, Platform_X_in2, Platform_X_in3, Platform_X_in4,
    input  Platform_X_in5, Platform_X_in6, Platform_X_in7, Platform_X_in8,
    input  Platform_Y_in1, Platform_Y_in2, Platform_Y_in3, Platform_Y_in4,
    input  Platform_Y_in5, Platform_Y_in6, Platform_Y_in7, Platform_Y_in8,
    output Land, Land_Index, Scroll_Dist, Result_valid, Busy
  );
endinterface

// File: rtl/platform_lander.sv
// Per-frame landing detector. On each rising edge of frame_clk it snapshots the doodle and
// all 8 platforms, tests one platform per cycle (lowest index wins), and publishes Land,
// Land_Index and the scroll distance for the next frame.
// Ports:
//   Clk    system clock
//   Reset  synchronous active-low reset
//   bus    platform_lander_if.slave (frame inputs in, scan results out)
module platform_lander #(
  parameter logic [9:0] platform_size = 10'd20,
  parameter logic [9:0] Doodle_Size   = 10'd8,
  parameter logic [9:0] Scroll_Line   = 10'd120
) (
  input logic              Clk,
  input logic              Reset,
  platform_lander_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSnap, StScan, StDone} state_e;

  state_e     state_q, state_d;
  logic       fc_q;
  logic [2:0] idx_q, idx_d;
  logic       hit_q, hit_d;
  logic [2:0] win_idx_q, win_idx_d;
  logic [9:0] win_y_q, win_y_d;
  logic       land_q, land_d;
  logic [2:0] land_idx_q, land_idx_d;
  logic [9:0] scroll_q, scroll_d;

  logic [9:0] dx_snap_q, dy_snap_q, dm_snap_q;
  logic [9:0] px_snap_q [8];
  logic [9:0] py_snap_q [8];
  logic [9:0] px_in [8];
  logic [9:0] py_in [8];

  assign px_in[0] = bus.Platform_X_in1;
  assign px_in[1] = bus.Platform_X_in2;
  assign px_in[2] = bus.Platform_X_in3;
  assign px_in[3] = bus.Platform_X_in4;
  assign px_in[4] = bus.Platform_X_in5;
  assign px_in[5] = bus.Platform_X_in6;
  assign px_in[6] = bus.Platform_X_in7;
  assign px_in[7] = bus.Platform_X_in8;
  assign py_in[0] = bus.Platform_Y_in1;
  assign py_in[1] = bus.Platform_Y_in2;
  assign py_in[2] = bus.Platform_Y_in3;
  assign py_in[3] = bus.Platform_Y_in4;
  assign py_in[4] = bus.Platform_Y_in5;
  assign py_in[5] = bus.Platform_Y_in6;
  assign py_in[6] = bus.Platform_Y_in7;
  assign py_in[7] = bus.Platform_Y_in8;

  logic start;
  assign start = bus.frame_clk & ~fc_q;

  // Hit test for the platform selected by idx_q, on snapshot values only.
  logic [9:0]  cur_px, cur_py, dx;
  logic [10:0] bot, nbot, reach;
  logic        falling, hit_now;

  assign cur_px  = px_snap_q[idx_q];
  assign cur_py  = py_snap_q[idx_q];
  assign falling = ~dm_snap_q[9] & (dm_snap_q != 10'd0);
  assign bot     = {1'b0, dy_snap_q} + {1'b0, Doodle_Size};
  assign nbot    = bot + {dm_snap_q[9], dm_snap_q};
  assign dx      = (dx_snap_q >= cur_px) ? dx_snap_q - cur_px : cur_px - dx_snap_q;
  assign reach   = {1'b0, platform_size} + {1'b0, Doodle_Size};
  assign hit_now = falling && (bot <= {1'b0, cur_py}) && (nbot >= {1'b0, cur_py}) &&
                   ({1'b0, dx} <= reach);

  // Final verdict including the platform tested in the last scan cycle.
  logic       fin_hit;
  logic [2:0] fin_idx;
  logic [9:0] fin_y;
  assign fin_hit = hit_q | hit_now;
  assign fin_idx = hit_q ? win_idx_q : (hit_now ? idx_q : 3'd0);
  assign fin_y   = hit_q ? win_y_q : cur_py;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    win_idx_d  = win_idx_q;
    win_y_d    = win_y_q;
    land_d     = land_q;
    land_idx_d = land_idx_q;
    scroll_d   = scroll_q;
    unique case (state_q)
      StIdle: if (start) state_d = StSnap;
      StSnap: begin
        hit_d     = 1'b0;
        win_idx_d = 3'd0;
        win_y_d   = 10'd0;
        idx_d     = 3'd0;
        state_d   = StScan;
      end
      StScan: begin
        if (hit_now && !hit_q) begin
          hit_d     = 1'b1;
          win_idx_d = idx_q;
          win_y_d   = cur_py;
        end
        if (idx_q == 3'd7) begin
          // Results are loaded on entry to DONE so they are valid alongside Result_valid.
          land_d     = fin_hit;
          land_idx_d = fin_idx;
          scroll_d   = (fin_hit && fin_y < Scroll_Line) ? Scroll_Line - fin_y : 10'd0;
          state_d    = StDone;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StIdle;
      fc_q       <= 1'b0;
      idx_q      <= 3'd0;
      hit_q      <= 1'b0;
      win_idx_q  <= 3'd0;
      win_y_q    <= 10'd0;
      land_q     <= 1'b0;
      land_idx_q <= 3'd0;
      scroll_q   <= 10'd0;
    end else begin
      state_q    <= state_d;
      fc_q       <= bus.frame_clk;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      win_idx_q  <= win_idx_d;
      win_y_q    <= win_y_d;
      land_q     <= land_d;
      land_idx_q <= land_idx_d;
      scroll_q   <= scroll_d;
    end
  end

  // Snapshot registers need no reset: they are always loaded in SNAP before being read.
  always_ff @(posedge Clk) begin
    if (state_q == StSnap) begin
      dx_snap_q <= bus.Doodle_X;
      dy_snap_q <= bus.Doodle_Y;
      dm_snap_q <= bus.Doodle_Y_Motion;
      for (int i = 0; i < 8; i++) begin
        px_snap_q[i] <= px_in[i];
        py_snap_q[i] <= py_in[i];
      end
    end
  end

  assign bus.Land         = land_q;
  assign bus.Land_Index   = land_idx_q;
  assign bus.Scroll_Dist  = scroll_q;
  assign bus.Result_valid = (state_q == StDone);
  assign bus.Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_platform_lander.sv
module tb_platform_lander;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  platform_lander_if bus ();

  platform_lander dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  task automatic set_plat(input int i, input logic [9:0] x, input logic [9:0] y);
    case (i)
      0: begin bus.Platform_X_in1 = x; bus.Platform_Y_in1 = y; end
      1: begin bus.Platform_X_in2 = x; bus.Platform_Y_in2 = y; end
      2: begin bus.Platform_X_in3 = x; bus.Platform_Y_in3 = y; end
      3: begin bus.Platform_X_in4 = x; bus.Platform_Y_in4 = y; end
      4: begin bus.Platform_X_in5 = x; bus.Platform_Y_in5 = y; end
      5: begin bus.Platform_X_in6 = x; bus.Platform_Y_in6 = y; end
      6: begin bus.Platform_X_in7 = x; bus.Platform_Y_in7 = y; end
      default: begin bus.Platform_X_in8 = x; bus.Platform_Y_in8 = y; end
    endcase
  endtask

  // Doodle state plus all platforms cleared to (0,0).
  task automatic setup(input logic [9:0] x, input logic [9:0] y, input logic [9:0] m);
    bus.Doodle_X        = x;
    bus.Doodle_Y        = y;
    bus.Doodle_Y_Motion = m;
    for (int i = 0; i < 8; i++) set_plat(i, 10'd0, 10'd0);
  endtask

  // Raise frame_clk and wait for Result_valid. lat = posedge count including the start edge,
  // or -1 on timeout. busy1 = Busy just after the start edge.
  task automatic run_scan(output int lat, output logic busy1);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    lat = -1;
    busy1 = 1'b0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge Clk);
      #1;
      if (n == 1) busy1 = bus.Busy;
      if (bus.Result_valid) lat = n;
    end
    @(negedge Clk);
    bus.frame_clk = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (bus.Land !== 1'b0) begin errors++; $display("FAIL reset_land got %b want 0", bus.Land); end
    checks++; if (bus.Land_Index !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.Land_Index); end
    checks++; if (bus.Scroll_Dist !== 10'd0) begin errors++; $display("FAIL reset_scroll got %0d want 0", bus.Scroll_Dist); end
    checks++; if (bus.Result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.Result_valid); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic busy1;
    setup(10'd150, 10'd100, 10'd4);
    set_plat(0, 10'd150, 10'd110);
    run_scan(lat, busy1);
    checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy1); end
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL basic_land got %b want 1", bus.Land); end
    checks++; if (bus.Land_Index !== 3'd0) begin errors++; $display("FAIL basic_idx got %0d want 0", bus.Land_Index); end
    checks++; if (bus.Scroll_Dist !== 10'd10) begin errors++; $display("FAIL basic_scroll got %0d want 10", bus.Scroll_Dist); end
    @(posedge Clk);
    #1;
    checks++; if (bus.Result_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", bus.Result_valid); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", bus.Busy); end
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL basic_hold got %b want 1", bus.Land); end
  endtask

  // Inputs changed mid-scan must not affect the result.
  task automatic test_snapshot;
    int lat;
    setup(10'd150, 10'd100, 10'd4);
    set_plat(0, 10'd150, 10'd110);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    bus.Doodle_Y_Motion = 10'h3FC;
    set_plat(0, 10'd150, 10'd0);
    lat = -1;
    for (int n = 4; n <= 20 && lat < 0; n++) begin
      @(posedge Clk);
      #1;
      if (bus.Result_valid) lat = n;
    end
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL snap_latency got %0d want 10", lat); end
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL snap_land got %b want 1", bus.Land); end
  endtask

  task automatic test_priority;
    int lat;
    logic busy1;
    setup(10'd150, 10'd100, 10'd4);
    set_plat(2, 10'd150, 10'd110);
    set_plat(5, 10'd150, 10'd110);
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL prio_land got %b want 1", bus.Land); end
    checks++; if (bus.Land_Index !== 3'd2) begin errors++; $display("FAIL prio_idx got %0d want 2", bus.Land_Index); end
    checks++; if (bus.Scroll_Dist !== 10'd10) begin errors++; $display("FAIL prio_scroll got %0d want 10", bus.Scroll_Dist); end
  endtask

  task automatic test_no_fall;
    int lat;
    logic busy1;
    setup(10'd150, 10'd100, 10'h3FC);
    set_plat(0, 10'd150, 10'd110);
    run_scan(lat, busy1);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rise_latency got %0d want 10", lat); end
    checks++; if (bus.Land !== 1'b0) begin errors++; $display("FAIL rise_land got %b want 0", bus.Land); end
    checks++; if (bus.Land_Index !== 3'd0) begin errors++; $display("FAIL rise_idx got %0d want 0", bus.Land_Index); end
    checks++; if (bus.Scroll_Dist !== 10'd0) begin errors++; $display("FAIL rise_scroll got %0d want 0", bus.Scroll_Dist); end
    bus.Doodle_Y_Motion = 10'd0;
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b0) begin errors++; $display("FAIL still_land got %b want 0", bus.Land); end
    checks++; if (bus.Scroll_Dist !== 10'd0) begin errors++; $display("FAIL still_scroll got %0d want 0", bus.Scroll_Dist); end
  endtask

  task automatic test_boundaries;
    int lat;
    logic busy1;
    setup(10'd150, 10'd100, 10'd4);
    set_plat(0, 10'd178, 10'd110);
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL dx28_land got %b want 1", bus.Land); end
    set_plat(0, 10'd179, 10'd110);
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b0) begin errors++; $display("FAIL dx29_land got %b want 0", bus.Land); end
    set_plat(0, 10'd122, 10'd110);
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL dxneg28_land got %b want 1", bus.Land); end
    set_plat(0, 10'd150, 10'd110);
    bus.Doodle_Y = 10'd102;
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL boteq_land got %b want 1", bus.Land); end
    checks++; if (bus.Scroll_Dist !== 10'd10) begin errors++; $display("FAIL boteq_scroll got %0d want 10", bus.Scroll_Dist); end
  endtask

  task automatic test_scroll;
    int lat;
    logic busy1;
    setup(10'd150, 10'd190, 10'd4);
    set_plat(0, 10'd150, 10'd200);
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL y200_land got %b want 1", bus.Land); end
    checks++; if (bus.Scroll_Dist !== 10'd0) begin errors++; $display("FAIL y200_scroll got %0d want 0", bus.Scroll_Dist); end
    bus.Doodle_Y = 10'd110;
    set_plat(0, 10'd150, 10'd120);
    run_scan(lat, busy1);
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL y120_land got %b want 1", bus.Land); end
    checks++; if (bus.Scroll_Dist !== 10'd0) begin errors++; $display("FAIL y120_scroll got %0d want 0", bus.Scroll_Dist); end
    set_plat(0, 10'd150, 10'd119);
    run_scan(lat, busy1);
    checks++; if (bus.Scroll_Dist !== 10'd1) begin errors++; $display("FAIL y119_scroll got %0d want 1", bus.Scroll_Dist); end
  endtask

  task automatic test_reset_abort;
    int lat;
    int pulses;
    logic busy1;
    setup(10'd150, 10'd100, 10'd4);
    set_plat(0, 10'd150, 10'd110);
    run_scan(lat, busy1);
    // Start a scan and reset during the SCAN cycle that tests index 4.
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    checks++; if (bus.Land !== 1'b0) begin errors++; $display("FAIL abort_land got %b want 0", bus.Land); end
    checks++; if (bus.Scroll_Dist !== 10'd0) begin errors++; $display("FAIL abort_scroll got %0d want 0", bus.Scroll_Dist); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge Clk);
      #1;
      if (bus.Result_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    run_scan(lat, busy1);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rescan_latency got %0d want 10", lat); end
    checks++; if (bus.Land !== 1'b1) begin errors++; $display("FAIL rescan_land got %b want 1", bus.Land); end
    // Level held high for 20 cycles must yield a single scan.
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge Clk);
      #1;
      if (bus.Result_valid) pulses++;
    end
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge Clk);
      #1;
      if (bus.Result_valid) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL level_pulses got %0d want 1", pulses); end
  endtask

  initial begin
    bus.frame_clk = 1'b0;
    setup(10'd0, 10'd0, 10'd0);
    test_reset();
    test_basic();
    test_snapshot();
    test_priority();
    test_no_fall();
    test_boundaries();
    test_scroll();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
